// File: rtl/sprite_blitter.sv
// Sprite drawer: walks a SPRITE_W x SPRITE_H row-major ROM image and emits
// one screen pixel per cycle, aligned to the ROM's one-cycle read latency.
module sprite_blitter #(
  parameter int                     SPRITE_W     = 63,
  parameter int                     SPRITE_H     = 59,
  parameter int                     ADDR_BITS    = 12,
  parameter int                     COLOUR_BITS  = 3,
  parameter int                     TRANS_EN     = 0,
  parameter logic [COLOUR_BITS-1:0] TRANS_COLOUR = '0
) (
  input  logic                   clock_all,
  input  logic                   reset_all,
  input  logic                   start,
  input  logic                   mirror,
  input  logic [8:0]             x_,
  input  logic [7:0]             y_,
  output logic [ADDR_BITS-1:0]   rom_address,
  input  logic [COLOUR_BITS-1:0] rom_q,
  output logic [8:0]             out_x,
  output logic [7:0]             out_y,
  output logic [COLOUR_BITS-1:0] out_colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  // Handshake: start is a request honoured only while idle (busy=0, done=0);
  // busy covers RUN and FLUSH, done pulses once after the last pixel and
  // plot qualifies out_x/out_y/out_colour in the same cycle.

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(SPRITE_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [ADDR_BITS-1:0] row_base;
  logic [8:0]           x0;
  logic [7:0]           y0;
  logic                 mirror_r;
  logic                 pix_valid;
  logic [CW-1:0]        col_x;
  logic                 last_pixel;

  assign last_pixel = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      x0        <= '0;
      y0        <= '0;
      mirror_r  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      pix_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pix_valid <= (state == S_RUN);
      case (state)
        S_IDLE: begin
          if (start) begin
            x0       <= x_;
            y0       <= y_;
            mirror_r <= mirror;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
          end
        end
        S_RUN: begin
          // Coordinate is registered here so it lines up with rom_q next cycle.
          out_x <= x0 + 9'(col);
          out_y <= y0 + 8'(row);
          if (col == LAST_COL) begin
            col      <= '0;
            row      <= row + 1'b1;
            row_base <= row_base + ADDR_BITS'(SPRITE_W);
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_pixel) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Mirroring only reorders ROM reads; screen x still counts up from x0.
  assign col_x       = mirror_r ? (LAST_COL - col) : col;
  assign rom_address = (state == S_RUN) ? (row_base + ADDR_BITS'(col_x)) : '0;

  assign out_colour = rom_q;
  assign plot       = pix_valid && !((TRANS_EN != 0) && (rom_q == TRANS_COLOUR));
  assign busy       = (state == S_RUN) || (state == S_FLUSH);
  assign done       = (state == S_DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter (4x3 sprite): one opaque and one transparent-7
// instance share stimulus; plotted pixels are scoreboarded against a model.
module tb_sprite_blitter;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock_all = 1'b0;
  logic       reset_all, start, mirror;
  logic [8:0] x_;
  logic [7:0] y_;

  logic [3:0] addr0, addr1;
  logic [2:0] q0, q1, col0, col1;
  logic [8:0] ox0, ox1;
  logic [7:0] oy0, oy1;
  logic       plot0, plot1, busy0, busy1, done0, done1;
  logic [1:0] st0, st1;

  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  logic [19:0] e0, e1;
  int checks = 0;
  int errors = 0;
  int plots0 = 0;
  int plots1 = 0;

  always #5 clock_all = ~clock_all;

  sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .ADDR_BITS(4), .COLOUR_BITS(3),
                   .TRANS_EN(0), .TRANS_COLOUR(3'd7)) u_dut0 (
    .clock_all(clock_all), .reset_all(reset_all), .start(start), .mirror(mirror),
    .x_(x_), .y_(y_), .rom_address(addr0), .rom_q(q0), .out_x(ox0), .out_y(oy0),
    .out_colour(col0), .plot(plot0), .busy(busy0), .done(done0), .dbg_state(st0));

  sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .ADDR_BITS(4), .COLOUR_BITS(3),
                   .TRANS_EN(1), .TRANS_COLOUR(3'd7)) u_dut1 (
    .clock_all(clock_all), .reset_all(reset_all), .start(start), .mirror(mirror),
    .x_(x_), .y_(y_), .rom_address(addr1), .rom_q(q1), .out_x(ox1), .out_y(oy1),
    .out_colour(col1), .plot(plot1), .busy(busy1), .done(done1), .dbg_state(st1));

  // ROM models: colour = address mod 8, one-cycle latency
  always @(posedge clock_all) begin
    q0 <= addr0[2:0];
    q1 <= addr1[2:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pix_addr(input int p, input logic m);
    int r, c;
    r = p / W;
    c = p % W;
    return r * W + (m ? (W - 1 - c) : c);
  endfunction

  function automatic logic [19:0] pix_word(input int p, input logic m,
                                           input int x, input int y);
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] pc;
    px = 9'((x + p % W) % 512);
    py = 8'((y + p / W) % 256);
    pc = 3'(pix_addr(p, m) % 8);
    return {px, py, pc};
  endfunction

  task automatic push_expected(input int x, input int y, input logic m, input int npix);
    for (int p = 0; p < npix; p++) begin
      exp_q0.push_back(pix_word(p, m, x, y));
      if (pix_addr(p, m) % 8 != 7) exp_q1.push_back(pix_word(p, m, x, y));
    end
  endtask

  // Monitors: every plot pops the matching instance's expected queue
  always @(negedge clock_all) begin
    if (plot0) begin
      plots0++;
      if (exp_q0.size() == 0) check("plot0_unexpected", 1, 0);
      else begin
        e0 = exp_q0.pop_front();
        check("pixel0", {12'd0, ox0, oy0, col0}, {12'd0, e0});
      end
    end
  end

  always @(negedge clock_all) begin
    if (plot1) begin
      plots1++;
      if (exp_q1.size() == 0) check("plot1_unexpected", 1, 0);
      else begin
        e1 = exp_q1.pop_front();
        check("pixel1", {12'd0, ox1, oy1, col1}, {12'd0, e1});
      end
    end
  end

  task automatic issue_start(input int x, input int y, input logic m);
    @(posedge clock_all); #1;
    x_ = 9'(x); y_ = 8'(y); mirror = m; start = 1'b1;
    @(posedge clock_all); #1;
    start = 1'b0; x_ = 9'h155; y_ = 8'hAA; mirror = ~m;
  endtask

  // Full draw with per-cycle timing checks over cycles 1..15
  task automatic draw(input int x, input int y, input logic m, input bit disturb);
    int p0, p1;
    logic exp_p0, exp_p1;
    push_expected(x, y, m, N);
    p0 = plots0; p1 = plots1;
    issue_start(x, y, m);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clock_all);
      check("rom_address", addr0, (k <= N) ? pix_addr(k - 1, m) : 0);
      check("busy", busy0, (k <= N + 1));
      check("done0", done0, (k == N + 2));
      check("done1", done1, (k == N + 2));
      exp_p0 = (k >= 2) && (k <= N + 1);
      exp_p1 = exp_p0 && (pix_addr(k - 2, m) % 8 != 7);
      check("plot0", plot0, exp_p0);
      check("plot1", plot1, exp_p1);
      start = disturb && (k == 3 || k == N + 2);
      if (start) begin x_ = 9'd100; y_ = 8'd100; end
    end
    start = 1'b0;
    check("plot0_count", plots0 - p0, N);
    check("plot1_count", plots1 - p1, N - 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_all = 1'b1; start = 1'b0; mirror = 1'b0; x_ = '0; y_ = '0;
    repeat (2) @(posedge clock_all);
    #1 reset_all = 1'b0;
    @(negedge clock_all);
    check("rst_addr", addr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_plot", plot0, 0);
    check("rst_state", st0, 0);

    // Basic: (10,20) colour 0 first, (13,22) colour 3 last; dut1 drops (13,21) in cycle 9
    draw(10, 20, 1'b0, 1'b0);
    check("hold_x_after_draw", ox0, 13);

    // Reset mid-idle clears the held coordinate
    @(posedge clock_all); #1 reset_all = 1'b1;
    repeat (2) @(posedge clock_all);
    #1 reset_all = 1'b0;
    @(negedge clock_all);
    check("idle_rst_x", ox0, 0);
    check("idle_rst_y", oy0, 0);
    check("idle_rst_addr", addr0, 0);
    check("idle_rst_plot", plot0, 0);
    check("idle_rst_busy", busy0, 0);
    check("idle_rst_done", done0, 0);

    // Mirror: addresses 3,2,1,0,7,6,5,4,... ; (13,21) colour 4
    draw(10, 20, 1'b1, 1'b0);
    // Wrap: x 510,511,0,1 and y 254,255,0
    draw(510, 254, 1'b0, 1'b0);

    // Abort: reset sampled at the end of cycle 5 -> only pixels 0..3 plot
    push_expected(10, 20, 1'b0, 4);
    issue_start(10, 20, 1'b0);
    for (int k = 1; k <= 5; k++) @(negedge clock_all);
    reset_all = 1'b1;
    @(negedge clock_all);
    check("abort_busy", busy0, 0);
    check("abort_plot0", plot0, 0);
    check("abort_plot1", plot1, 0);
    check("abort_addr", addr0, 0);
    reset_all = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_all);
      check("abort_no_done", done0 | done1, 0);
    end

    // Reissue with ignored start pulses in cycles 3 and 14
    draw(10, 20, 1'b0, 1'b1);
    @(negedge clock_all);
    check("post_ignore_busy", busy0, 0);

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite drawer, successor to the fixed 63x59 trainer drawer. On a `start` pulse it walks a SPRITE_W x SPRITE_H sprite stored row-major in an external synchronous ROM. For each pixel it emits a screen coordinate, colour and `plot` strobe to the VGA adapter. It adds a start/busy/done handshake, ROM-latency alignment, optional transparent-colour skipping and horizontal mirroring, so one block serves trainer, Pokémon and UI sprites.

## Interface
Parameters:
- SPRITE_W, 63, sprite width in pixels (≥1)
- SPRITE_H, 59, sprite height in pixels (≥1)
- ADDR_BITS, 12, ROM address width; SPRITE_W*SPRITE_H ≤ 2^ADDR_BITS
- COLOUR_BITS, 3, colour width
- TRANS_EN, 0, 1 = suppress `plot` for pixels equal to TRANS_COLOUR
- TRANS_COLOUR, 0, transparent colour value

Ports:
- clock_all  in  1  single clock, all logic on rising edge
- reset_all  in  1  synchronous, active-high reset
- start  in  1  begin a draw; honoured only in IDLE
- mirror  in  1  horizontal flip; sampled with `start`
- x_  in  9  screen x origin; sampled with `start`
- y_  in  8  screen y origin; sampled with `start`
- rom_address  out  ADDR_BITS  sprite ROM read address
- rom_q  in  COLOUR_BITS  ROM data; valid one cycle after its address
- out_x  out  9  pixel screen x
- out_y  out  8  pixel screen y
- out_colour  out  COLOUR_BITS  pixel colour, driven directly from rom_q
- plot  out  1  write strobe for out_x/out_y/out_colour
- busy  out  1  draw in progress
- done  out  1  one-cycle pulse at draw completion

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - With `start`=1, latch x_, y_ and mirror; clear col/row; go to RUN.
  - `start` in any other state is ignored.
- RUN:
  - Each cycle presents the address for pixel (col,row).
  - Address is row*SPRITE_W + col, or row*SPRITE_W + (SPRITE_W-1-col) when mirror=1.
  - Row base is held in a register advanced by SPRITE_W per row. No multiplier.
  - col increments each cycle. At col = SPRITE_W-1: col←0 and row increments.
  - At the last pixel (col = SPRITE_W-1, row = SPRITE_H-1) go to FLUSH.
- Output stage:
  - The pixel coordinate is delayed one register stage to align with rom_q.
  - out_x = x0 + col_d, truncated to 9 bits (wraps).
  - out_y = y0 + row_d, truncated to 8 bits (wraps).
- `plot`:
  - High in the cycle after each RUN cycle.
  - Low when TRANS_EN=1 and rom_q = TRANS_COLOUR.
- FLUSH: emits the final pixel, then goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Mirroring changes only the ROM address order. Screen x always increases left to right.
- Reset values, from reset_all=1 in any state:
  - State returns to IDLE.
  - rom_address, out_x, out_y, col, row and latched origin/mirror are 0.
  - plot, busy and done are 0.
  - out_colour follows rom_q.
  - An aborted draw never asserts `done`.

## Timing
- Let N = SPRITE_W*SPRITE_H. `start` is sampled at edge E0; cycle k is the cycle after edge Ek-1.
- RUN occupies cycles 1..N; pixel k-1's address appears in cycle k.
- Pixel k-1's out_x/out_y/out_colour/plot are valid in cycle k+1, i.e. cycles 2..N+1. Cycle N+1 is FLUSH.
- `busy` is high for cycles 1..N+1.
- `done` is high in cycle N+2, with busy=0.
- A new `start` is accepted from cycle N+3 onward; `start` during cycle N+2 (DONE) is ignored.
- Throughput: 1 pixel/cycle. Total draw time is N+2 cycles from start to done.
- Transparency never changes cycle count; only `plot` is masked.
- With `plot`=0, out_x/out_y hold their last values. Consumers must qualify them with `plot`.

## Test plan
Bench parameters: SPRITE_W=4, SPRITE_H=3. ROM model holds colour = address mod 8, with 1-cycle latency.

- Reset: hold reset_all 2 cycles mid-idle -> rom_address=0, out_x=0, out_y=0, plot=0, busy=0, done=0.
- Basic draw, x_=10, y_=20, TRANS_EN=0, start pulse ->
  - addresses 0..11 in cycles 1..12;
  - 12 plot cycles in cycles 2..13, first (10,20) colour 0, last (13,22) colour 3;
  - busy cycles 1..13; done only in cycle 14.
- Mirror=1, same origin ->
  - row 0 addresses 3,2,1,0; row 1 addresses 7,6,5,4;
  - first plot (10,20) colour 3; pixel (13,21) colour 4.
- Transparency, TRANS_EN=1, TRANS_COLOUR=7 ->
  - plot low only for address 7 at (13,21), cycle 9;
  - 11 plots total; done still in cycle 14.
- Wrap, x_=510, y_=254 ->
  - row 0 out_x sequence 510,511,0,1;
  - rows at out_y 254,255,0.
- Abort and reissue:
  - reset_all in cycle 5 -> next cycle busy=0, plot=0, and no done pulse follows.
  - Fresh start -> full 14-cycle draw.
  - start pulses in cycles 3 and 14 of that draw are ignored.
